// File: rtl/cp_timing_detect_pkg.sv
// Package: cp_timing_detect_pkg
// Shared types, sizes and helpers for the cyclic-prefix timing detector.
//   phi_t        unsigned-looking Q6.8 word carrying phi / |gamma| (sign-extended)
//   metric_t     signed timing metric lambda = |gamma| - phi, one bit wider
//   sym_idx_t    sample index within one symbol period
//   lock_cnt_t   hit/miss counter for the lock FSM
//   tdet_state_e lock FSM state encoding (matches state_out)
package cp_timing_detect_pkg;

  localparam int N_FFT    = 64;
  localparam int CP_LEN   = 16;
  localparam int LOCK_CNT = 3;
  localparam int TOL      = 1;
  localparam int PHI_W    = 14;
  localparam int SYM_LEN  = N_FFT + CP_LEN;
  localparam int IDX_W    = $clog2(SYM_LEN);
  localparam int CNT_W    = $clog2(LOCK_CNT + 1);

  typedef logic [PHI_W-1:0]        phi_t;
  typedef logic signed [PHI_W:0]   metric_t;
  typedef logic [IDX_W-1:0]        sym_idx_t;
  typedef logic [CNT_W-1:0]        lock_cnt_t;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } tdet_state_e;

  localparam sym_idx_t  IDX_ZERO = sym_idx_t'(0);
  localparam sym_idx_t  IDX_ONE  = sym_idx_t'(1);
  localparam sym_idx_t  LAST_IDX = sym_idx_t'(SYM_LEN - 1);
  localparam sym_idx_t  SYM_LEN_IDX = sym_idx_t'(SYM_LEN);
  localparam sym_idx_t  TOL_IDX  = sym_idx_t'(TOL);
  localparam lock_cnt_t CNT_ZERO = lock_cnt_t'(0);
  localparam lock_cnt_t CNT_ONE  = lock_cnt_t'(1);
  localparam lock_cnt_t CNT_MAX  = lock_cnt_t'(LOCK_CNT);

  // Circular distance between two symbol indices, so 79 and 0 are 1 apart.
  function automatic sym_idx_t circ_dist(input sym_idx_t a, input sym_idx_t b);
    sym_idx_t d;
    sym_idx_t w;
    if (a >= b) begin
      d = a - b;
    end else begin
      d = b - a;
    end
    w = SYM_LEN_IDX - d;
    if (w < d) begin
      circ_dist = w;
    end else begin
      circ_dist = d;
    end
  endfunction

endpackage

// File: rtl/cp_timing_detect_sym_argmax.sv
// Module: cp_timing_detect_sym_argmax
// Forms lambda per valid sample, tracks the running argmax over one symbol
// period and reports the winner one clock after the last sample.
//   clk, rst_n          clock, async active-low reset
//   clear               synchronous restart (index back to 0, no report)
//   in_valid            phi_in / gamma_mag valid this cycle
//   phi_in, gamma_mag   Q6.8 inputs
//   theta, peak         registered argmax index / metric of the last symbol
//   report              1-cycle pulse when theta/peak update
//   sym_done            combinational: this cycle closes a symbol
//   fin_theta, fin_peak combinational winner of the closing symbol
module cp_timing_detect_sym_argmax
  import cp_timing_detect_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     clear,
  input  logic     in_valid,
  input  phi_t     phi_in,
  input  phi_t     gamma_mag,
  output sym_idx_t theta,
  output metric_t  peak,
  output logic     report,
  output logic     sym_done,
  output sym_idx_t fin_theta,
  output metric_t  fin_peak
);

  sym_idx_t idx_r;
  metric_t  best_r;
  sym_idx_t best_idx_r;
  sym_idx_t theta_r;
  metric_t  peak_r;
  logic     report_r;

  metric_t  lambda_s;
  metric_t  run_best_s;
  sym_idx_t run_idx_s;

  // One extra bit makes the difference of two sign-extended words exact.
  assign lambda_s = $signed({gamma_mag[PHI_W-1], gamma_mag})
                  - $signed({phi_in[PHI_W-1], phi_in});

  // Running max including the current sample; strict > keeps the earliest tie.
  always_comb begin
    run_best_s = best_r;
    run_idx_s  = best_idx_r;
    if (idx_r == IDX_ZERO) begin
      run_best_s = lambda_s;
      run_idx_s  = IDX_ZERO;
    end else if (lambda_s > best_r) begin
      run_best_s = lambda_s;
      run_idx_s  = idx_r;
    end else begin
      run_best_s = best_r;
      run_idx_s  = best_idx_r;
    end
  end

  assign sym_done  = in_valid & ~clear & (idx_r == LAST_IDX);
  assign fin_theta = run_idx_s;
  assign fin_peak  = run_best_s;

  // Sample index, running max and the registered per-symbol report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r      <= IDX_ZERO;
      best_r     <= '0;
      best_idx_r <= IDX_ZERO;
      theta_r    <= IDX_ZERO;
      peak_r     <= '0;
      report_r   <= 1'b0;
    end else if (clear) begin
      // theta/peak deliberately keep the last report across a restart
      idx_r      <= IDX_ZERO;
      best_r     <= '0;
      best_idx_r <= IDX_ZERO;
      report_r   <= 1'b0;
    end else begin
      report_r <= sym_done;
      if (in_valid) begin
        best_r     <= run_best_s;
        best_idx_r <= run_idx_s;
        if (idx_r == LAST_IDX) begin
          idx_r   <= IDX_ZERO;
          theta_r <= run_idx_s;
          peak_r  <= run_best_s;
        end else begin
          idx_r <= idx_r + IDX_ONE;
        end
      end
    end
  end

  assign theta  = theta_r;
  assign peak   = peak_r;
  assign report = report_r;

endmodule

// File: rtl/cp_timing_detect.sv
// Module: cp_timing_detect
// CP timing detector: per-symbol argmax of lambda = |gamma| - phi, qualified
// by a SEARCH / VERIFY / LOCKED FSM using circular index consistency.
//   clk, rst_n        clock, async active-low reset
//   clear             synchronous restart: FSM to SEARCH, sample index to 0
//   in_valid          phi_in / gamma_mag valid
//   phi_in, gamma_mag Q6.8 energy and correlation magnitude
//   thresh            minimum peak (strict) for a report to be a candidate
//   theta_out         argmax index of the last symbol
//   peak_out          lambda at theta_out
//   theta_valid       1-cycle pulse when theta_out / peak_out update
//   locked            FSM in LOCKED
//   state_out         FSM state (0 SEARCH, 1 VERIFY, 2 LOCKED)
module cp_timing_detect
  import cp_timing_detect_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       in_valid,
  input  phi_t       phi_in,
  input  phi_t       gamma_mag,
  input  metric_t    thresh,
  output sym_idx_t   theta_out,
  output metric_t    peak_out,
  output logic       theta_valid,
  output logic       locked,
  output logic [1:0] state_out
);

  logic        sym_done_s;
  sym_idx_t    fin_theta_s;
  metric_t     fin_peak_s;
  logic        good_s;
  logic        cons_s;

  tdet_state_e state_r, state_n_s;
  sym_idx_t    ref_r, ref_n_s;
  lock_cnt_t   hit_r, hit_n_s;
  lock_cnt_t   miss_r, miss_n_s;
  logic        locked_r;

  cp_timing_detect_sym_argmax u_argmax (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .phi_in    (phi_in),
    .gamma_mag (gamma_mag),
    .theta     (theta_out),
    .peak      (peak_out),
    .report    (theta_valid),
    .sym_done  (sym_done_s),
    .fin_theta (fin_theta_s),
    .fin_peak  (fin_peak_s)
  );

  // The FSM judges the winner in the same edge that registers the report,
  // so state_out / locked change together with theta_valid.
  assign good_s = (fin_peak_s > thresh);
  assign cons_s = (circ_dist(fin_theta_s, ref_r) <= TOL_IDX);

  // Lock FSM next-state logic, evaluated only on symbol-closing samples.
  always_comb begin
    state_n_s = state_r;
    ref_n_s   = ref_r;
    hit_n_s   = hit_r;
    miss_n_s  = miss_r;
    if (sym_done_s) begin
      case (state_r)
        ST_SEARCH: begin
          if (good_s) begin
            state_n_s = ST_VERIFY;
            ref_n_s   = fin_theta_s;
            hit_n_s   = CNT_ONE;
          end else begin
            hit_n_s   = CNT_ZERO;
          end
        end
        ST_VERIFY: begin
          if (good_s && cons_s) begin
            if ((hit_r + CNT_ONE) == CNT_MAX) begin
              state_n_s = ST_LOCKED;
              hit_n_s   = CNT_ZERO;
              miss_n_s  = CNT_ZERO;
            end else begin
              hit_n_s   = hit_r + CNT_ONE;
            end
          end else if (good_s) begin
            ref_n_s = fin_theta_s;
            hit_n_s = CNT_ONE;
          end else begin
            state_n_s = ST_SEARCH;
            hit_n_s   = CNT_ZERO;
          end
        end
        ST_LOCKED: begin
          if (good_s && cons_s) begin
            miss_n_s = CNT_ZERO;
            ref_n_s  = fin_theta_s;
          end else if ((miss_r + CNT_ONE) == CNT_MAX) begin
            state_n_s = ST_SEARCH;
            miss_n_s  = CNT_ZERO;
            hit_n_s   = CNT_ZERO;
          end else begin
            miss_n_s  = miss_r + CNT_ONE;
          end
        end
        default: begin
          state_n_s = ST_SEARCH;
          hit_n_s   = CNT_ZERO;
          miss_n_s  = CNT_ZERO;
        end
      endcase
    end else begin
      state_n_s = state_r;
    end
  end

  // Lock FSM state, reference index, hit/miss counters and locked flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_SEARCH;
      ref_r    <= IDX_ZERO;
      hit_r    <= CNT_ZERO;
      miss_r   <= CNT_ZERO;
      locked_r <= 1'b0;
    end else if (clear) begin
      state_r  <= ST_SEARCH;
      ref_r    <= IDX_ZERO;
      hit_r    <= CNT_ZERO;
      miss_r   <= CNT_ZERO;
      locked_r <= 1'b0;
    end else begin
      state_r  <= state_n_s;
      ref_r    <= ref_n_s;
      hit_r    <= hit_n_s;
      miss_r   <= miss_n_s;
      locked_r <= (state_n_s == ST_LOCKED);
    end
  end

  assign locked    = locked_r;
  assign state_out = state_r;

endmodule

// File: tb/tb_cp_timing_detect.sv
// Testbench for cp_timing_detect: scenario tasks drive symbols and push the
// expected report into a queue; a monitor pops and compares on theta_valid.
module tb_cp_timing_detect;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clear;
  logic               in_valid;
  logic [13:0]        phi_in;
  logic [13:0]        gamma_mag;
  logic signed [14:0] thresh;
  logic [6:0]         theta_out;
  logic signed [14:0] peak_out;
  logic               theta_valid;
  logic               locked;
  logic [1:0]         state_out;

  int     checks   = 0;
  int     failures = 0;
  longint cyc      = 0;

  typedef struct {
    int     theta;
    int     peak;
    int     st;
    longint cyc;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  cp_timing_detect dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .in_valid    (in_valid),
    .phi_in      (phi_in),
    .gamma_mag   (gamma_mag),
    .thresh      (thresh),
    .theta_out   (theta_out),
    .peak_out    (peak_out),
    .theta_valid (theta_valid),
    .locked      (locked),
    .state_out   (state_out)
  );

  // Scoreboard monitor: every theta_valid pulse must match the queue head.
  initial begin : monitor
    exp_t e;
    logic prev_tv;
    prev_tv = 1'b0;
    forever begin
      @(negedge clk);
      if (theta_valid && prev_tv) begin
        checks++; failures++;
        $display("FAIL pulse_width: theta_valid high on two consecutive cycles");
      end
      if (theta_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_report: theta_out=%0d peak_out=%0d with no report expected",
                   theta_out, peak_out);
        end else begin
          e = exp_q.pop_front();
          if (int'(theta_out) !== e.theta) begin
            failures++;
            $display("FAIL theta: got %0d expected %0d", theta_out, e.theta);
          end
          checks++;
          if (int'(peak_out) !== e.peak) begin
            failures++;
            $display("FAIL peak: got %0d expected %0d", peak_out, e.peak);
          end
          checks++;
          if (int'(state_out) !== e.st) begin
            failures++;
            $display("FAIL state: got %0d expected %0d", state_out, e.st);
          end
          checks++;
          if (locked !== (e.st == 2)) begin
            failures++;
            $display("FAIL locked: got %0b expected %0b", locked, (e.st == 2));
          end
          checks++;
          if (cyc !== e.cyc) begin
            failures++;
            $display("FAIL latency: report at cycle %0d expected cycle %0d", cyc, e.cyc);
          end
        end
      end
      prev_tv = theta_valid;
    end
  end

  // One valid sample carrying metric lam, then 0..gap_max idle cycles.
  task automatic drive_sample(input int lam, input int gap_max);
    int ph;
    int n;
    ph = $urandom_range(5, 400);
    @(negedge clk);
    in_valid  = 1'b1;
    phi_in    = 14'(ph);
    gamma_mag = 14'(lam + ph);
    n = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Full symbol: base -5, v1 at p1, v2 at p2; expected report pushed on the last sample.
  task automatic send_sym(input int p1, input int v1, input int p2, input int v2,
                          input int gap_max, input bit b2b,
                          input int e_theta, input int e_peak, input int e_st);
    exp_t e;
    int lam;
    for (int i = 0; i < 80; i++) begin
      lam = -5;
      if (i == p1) lam = v1;
      else if (i == p2) lam = v2;
      drive_sample(lam, (i == 79) ? 0 : gap_max);
    end
    e.theta = e_theta; e.peak = e_peak; e.st = e_st; e.cyc = cyc + 1;
    exp_q.push_back(e);
    if (!b2b) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic send_partial(input int n, input int p, input int v);
    for (int i = 0; i < n; i++) drive_sample((i == p) ? v : -5, 0);
  endtask

  task automatic do_clear();
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
    phi_in = 14'd0; gamma_mag = 14'd0; thresh = 15'sd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (theta_out !== 7'd0) begin failures++; $display("FAIL reset_theta: got %0d expected 0", theta_out); end
    checks++; if (peak_out !== 15'sd0) begin failures++; $display("FAIL reset_peak: got %0d expected 0", peak_out); end
    checks++; if (theta_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", theta_valid); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked: got %0b expected 0", locked); end
    checks++; if (state_out !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", state_out); end
  endtask

  task automatic test_peak();
    send_sym(37, 100, -1, 0, 0, 1'b0, 37, 100, 1);
  endtask

  task automatic test_tie();
    send_sym(10, 50, 60, 50, 0, 1'b0, 10, 50, 1);
  endtask

  task automatic test_lock();
    do_clear();
    send_sym(20, 100, -1, 0, 0, 1'b0, 20, 100, 1);
    send_sym(21, 100, -1, 0, 0, 1'b0, 21, 100, 1);
    send_sym(20, 100, -1, 0, 0, 1'b0, 20, 100, 2);
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL lock_hold: got %0b expected 1", locked); end
  endtask

  task automatic test_track();
    do_clear();
    send_sym(79, 90, -1, 0, 0, 1'b0, 79, 90, 1);
    send_sym(79, 90, -1, 0, 0, 1'b0, 79, 90, 1);
    send_sym(79, 90, -1, 0, 0, 1'b0, 79, 90, 2);
    send_sym(0, 90, -1, 0, 0, 1'b0, 0, 90, 2);
    send_sym(40, 90, -1, 0, 0, 1'b0, 40, 90, 2);
    send_sym(40, 90, -1, 0, 0, 1'b0, 40, 90, 2);
    send_sym(40, 90, -1, 0, 0, 1'b0, 40, 90, 0);
  endtask

  task automatic test_thresh();
    do_clear();
    thresh = 15'sd40;
    send_sym(5, 50, -1, 0, 0, 1'b0, 5, 50, 1);
    send_sym(5, 30, -1, 0, 0, 1'b0, 5, 30, 0);
    send_sym(5, 40, -1, 0, 0, 1'b0, 5, 40, 0);
    thresh = 15'sd0;
  endtask

  task automatic test_gaps();
    do_clear();
    send_sym(55, 77, -1, 0, 5, 1'b0, 55, 77, 1);
    send_sym(55, 77, -1, 0, 5, 1'b0, 55, 77, 1);
  endtask

  task automatic test_back_to_back();
    do_clear();
    send_sym(3, 90, -1, 0, 0, 1'b1, 3, 90, 1);
    send_sym(3, 90, -1, 0, 0, 1'b1, 3, 90, 1);
    send_sym(3, 90, -1, 0, 0, 1'b0, 3, 90, 2);
  endtask

  task automatic test_async_reset();
    send_partial(45, 30, 300);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (theta_out !== 7'd0) begin failures++; $display("FAIL arst_theta: got %0d expected 0", theta_out); end
    checks++; if (peak_out !== 15'sd0) begin failures++; $display("FAIL arst_peak: got %0d expected 0", peak_out); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL arst_locked: got %0b expected 0", locked); end
    checks++; if (state_out !== 2'd0) begin failures++; $display("FAIL arst_state: got %0d expected 0", state_out); end
    @(negedge clk);
    rst_n = 1'b1;
    send_sym(12, 60, -1, 0, 0, 1'b0, 12, 60, 1);
  endtask

  task automatic test_clear();
    send_partial(45, 3, 200);
    @(negedge clk);
    in_valid  = 1'b1;
    clear     = 1'b1;
    phi_in    = 14'd10;
    gamma_mag = 14'd5;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    checks++; if (theta_valid !== 1'b0) begin failures++; $display("FAIL clr_valid: got %0b expected 0", theta_valid); end
    checks++; if (state_out !== 2'd0) begin failures++; $display("FAIL clr_state: got %0d expected 0", state_out); end
    checks++; if (theta_out !== 7'd12) begin failures++; $display("FAIL clr_theta_hold: got %0d expected 12", theta_out); end
    checks++; if (peak_out !== 15'sd60) begin failures++; $display("FAIL clr_peak_hold: got %0d expected 60", peak_out); end
    send_sym(66, 70, -1, 0, 0, 1'b0, 66, 70, 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d reports still outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_peak();
    test_tie();
    test_lock();
    test_track();
    test_thresh();
    test_gaps();
    test_back_to_back();
    test_async_reset();
    test_clear();
    wait_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
